dp_ram_ctrl: RTL and testbench
==============================

// Module: dp_ram_ctrl
// PURPOSE
//  Initiator/sequencer for the dual-bank sync RAM (cs=1 selects bank A, cs=0 bank B; we=1 write).
//  Two clients (A, B) issue read/write requests over valid/ready. The block arbitrates, drives one
//  RAM op per transaction and returns a one-cycle response pulse carrying read data or a write ack.
//  Sits between client logic and the RAM; it is the only master of the RAM pins.
// PARAMETERS
//  AW  3  address width (RAM depth = 1<<AW)
//  DW  3  data width
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   synchronous reset, active-low
//  a_req_valid  in   1   client A request valid
//  a_req_ready  out  1   client A request accepted when valid&ready
//  a_req_we     in   1   1=write, 0=read
//  a_req_addr   in   AW  client A address (bank A)
//  a_req_wdata  in   DW  client A write data
//  a_rsp_valid  out  1   one-cycle response pulse to A
//  a_rsp_rdata  out  DW  read data (0 for write ack)
//  b_*          --   --  identical set for client B (bank B)
//  ram_cs       out  1   1=bank A, 0=bank B
//  ram_we       out  1   RAM write enable
//  ram_addr_a   out  AW  ram_addr_b out AW
//  ram_data_a   out  DW  ram_data_b out DW
//  ram_data_aout in  DW  ram_data_bout in DW  (RAM sync-read outputs)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE; all outputs 0 except ram_cs=1; cmd reg cleared;
//    in-flight op dropped, no rsp pulse. ram_we=0 guaranteed during and after reset.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE; throughput one op per 3 cycles.
//  - IDLE: ready asserted only to granted client (combinational from valids + priority);
//    at most one ready high. Handshake at edge k latches {port,we,addr,wdata} -> ISSUE.
//    No valid: stay IDLE.
//  - ISSUE (cycle k+1): ram_cs/ram_we/addr/data driven from cmd reg (registered outputs);
//    RAM executes at end of this cycle. Unselected bank address/data driven 0.
//  - RESP (cycle k+2): ram_we=0, ram_cs held; x_rsp_valid=1 for owning port only;
//    read: x_rsp_rdata = ram_data_xout; write: x_rsp_rdata = 0. Other port rsp_valid=0.
//  - Outside ISSUE ram_we=0 always; no write can reach the RAM except in ISSUE.
//  - Requests are not accepted in ISSUE/RESP (ready=0); clients hold valid and payload stable.
//  - Simultaneous valid: arbitration per CONFIGURATION. Loser keeps valid, served next IDLE.
//  - Read-after-write same addr in back-to-back transactions returns the newly written value.
//  - Response has no backpressure; clients must accept the pulse.
// CONFIGURATION
//  DP_RAM_CTRL_RR_EN defined: round-robin; last-granted pointer (reset=B, so A wins first tie),
//    toggles on each grant; a tie goes to the port not last granted.
//  Undefined: fixed priority, A always wins ties (B may starve under continuous A traffic).
// STRUCTURE
//  Package dp_ram_pkg: AW/DW defaults, state enum (IDLE/ISSUE/RESP), port-select constants
//    (PORT_A=1'b1, PORT_B=1'b0), cmd struct {port,we,addr,wdata}.
//  Sub-module dp_ram_arb: 2-way arbiter (valids, rr enable, advance -> grant one-hot);
//    RR pointer lives inside it. FSM, cmd register and response mux stay top-level.
// TESTING  (AW=3, DW=3, bench instantiates the RAM model)
//  1. Reset held 3 cycles with a_req_valid=1 -> no ready, ram_we=0, rsp_valid=0; after release,
//     A is granted first IDLE cycle.
//  2. A write addr=5 data=3, then A read addr=5 -> a_rsp_valid at k+2 each; read rdata=3; write rdata=0.
//  3. B write addr=2 data=6, A read addr=2 -> A returns bank-A content (0 from prior init), B bank
//     unaffected; B read addr=2 returns 6.
//  4. A and B valid continuously for 6 grants: RR_EN -> grants A,B,A,B,A,B;
//     without -> A x6, B ready never high.
//  5. rst_n low during ISSUE of a write addr=1 data=7 -> no rsp pulse; subsequent read addr=1
//     returns prior value, not 7.

Source files
------------

// File: rtl/dp_ram_pkg.sv
// Shared types and constants for the dual-bank RAM sequencer.
package dp_ram_pkg;

  localparam int unsigned AW_DEF = 3;
  localparam int unsigned DW_DEF = 3;

  // Port select doubles as the RAM bank select (ram_cs).
  localparam logic PORT_A = 1'b1;
  localparam logic PORT_B = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic              port;
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/dp_ram_arb.sv
// Two-way request arbiter: fixed priority (A wins) or round-robin when rr_en is set.
// grant is one-hot {A, B}; the last-granted pointer moves only when advance is high.
module dp_ram_arb
  import dp_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_a,
  input  logic       valid_b,
  input  logic       rr_en,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;
  logic grant_a;
  logic grant_b;

  // Tie goes to A unless round-robin says A was served last.
  always_comb begin
    grant_a = valid_a & (~valid_b | ~rr_en | (last_q == PORT_B));
    grant_b = valid_b & ~grant_a;
    grant   = {grant_a, grant_b};
  end

  // Last-granted pointer; reset to B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= PORT_B;
    end else if (advance && (grant_a || grant_b)) begin
      last_q <= grant_a ? PORT_A : PORT_B;
    end
  end

endmodule

// File: rtl/dp_ram_ctrl.sv
// Sequencer for the dual-bank sync RAM: arbitrates two clients, issues one RAM op per
// transaction (IDLE -> ISSUE -> RESP) and returns a one-cycle response pulse.
// Optional feature: define DP_RAM_CTRL_RR_EN for round-robin arbitration (else A has priority).
module dp_ram_ctrl
  import dp_ram_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req_valid,
  output logic          a_req_ready,
  input  logic          a_req_we,
  input  logic [AW-1:0] a_req_addr,
  input  logic [DW-1:0] a_req_wdata,
  output logic          a_rsp_valid,
  output logic [DW-1:0] a_rsp_rdata,
  input  logic          b_req_valid,
  output logic          b_req_ready,
  input  logic          b_req_we,
  input  logic [AW-1:0] b_req_addr,
  input  logic [DW-1:0] b_req_wdata,
  output logic          b_rsp_valid,
  output logic [DW-1:0] b_rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_a,
  output logic [DW-1:0] ram_data_b,
  input  logic [DW-1:0] ram_data_aout,
  input  logic [DW-1:0] ram_data_bout
);

`ifdef DP_RAM_CTRL_RR_EN
  localparam logic RrEn = 1'b1;
`else
  localparam logic RrEn = 1'b0;
`endif

  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [1:0] grant;
  logic       in_idle;
  logic       take;
  logic       issue;
  logic       resp;
  logic       sel_a;

  assign in_idle = rst_n && (state_q == IDLE);
  assign take    = in_idle && (grant != 2'b00);

  dp_ram_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_a (a_req_valid),
    .valid_b (b_req_valid),
    .rr_en   (RrEn),
    .advance (take),
    .grant   (grant)
  );

  // Next-state and command capture on handshake.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      IDLE: begin
        if (grant[1]) begin
          cmd_d   = '{port: PORT_A, we: a_req_we, addr: a_req_addr, wdata: a_req_wdata};
          state_d = ISSUE;
        end else if (grant[0]) begin
          cmd_d   = '{port: PORT_B, we: b_req_we, addr: b_req_addr, wdata: b_req_wdata};
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and command registers; reset leaves bank A selected and drops any in-flight op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '{port: PORT_A, default: '0};
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
    end
  end

  // RAM pins and responses decode from registered state; rst_n gates them so that no write
  // or response can escape while reset is asserted mid-transaction.
  always_comb begin
    issue       = rst_n && (state_q == ISSUE);
    resp        = rst_n && (state_q == RESP);
    sel_a       = (cmd_q.port == PORT_A);
    a_req_ready = in_idle & grant[1];
    b_req_ready = in_idle & grant[0];
    ram_cs      = ~rst_n | cmd_q.port;
    ram_we      = issue & cmd_q.we;
    ram_addr_a  = (issue && sel_a)  ? cmd_q.addr  : '0;
    ram_data_a  = (issue && sel_a)  ? cmd_q.wdata : '0;
    ram_addr_b  = (issue && !sel_a) ? cmd_q.addr  : '0;
    ram_data_b  = (issue && !sel_a) ? cmd_q.wdata : '0;
    a_rsp_valid = resp & sel_a;
    b_rsp_valid = resp & ~sel_a;
    a_rsp_rdata = (a_rsp_valid && !cmd_q.we) ? ram_data_aout : '0;
    b_rsp_rdata = (b_rsp_valid && !cmd_q.we) ? ram_data_bout : '0;
  end

endmodule

// File: tb/tb_dp_ram_ctrl.sv
// Self-checking bench for dp_ram_ctrl with a dual-bank sync RAM model and a
// transaction-level reference (memory arrays plus grant-pointer rule).
module tb_dp_ram_ctrl;

`ifdef DP_RAM_CTRL_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [2:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic       b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [2:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic       ram_cs, ram_we;
  logic [2:0] ram_addr_a, ram_addr_b, ram_data_a, ram_data_b;
  logic [2:0] ram_data_aout, ram_data_bout;

  always #5 clk = ~clk;

  dp_ram_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a_req_valid   (a_req_valid),
    .a_req_ready   (a_req_ready),
    .a_req_we      (a_req_we),
    .a_req_addr    (a_req_addr),
    .a_req_wdata   (a_req_wdata),
    .a_rsp_valid   (a_rsp_valid),
    .a_rsp_rdata   (a_rsp_rdata),
    .b_req_valid   (b_req_valid),
    .b_req_ready   (b_req_ready),
    .b_req_we      (b_req_we),
    .b_req_addr    (b_req_addr),
    .b_req_wdata   (b_req_wdata),
    .b_rsp_valid   (b_rsp_valid),
    .b_rsp_rdata   (b_rsp_rdata),
    .ram_cs        (ram_cs),
    .ram_we        (ram_we),
    .ram_addr_a    (ram_addr_a),
    .ram_addr_b    (ram_addr_b),
    .ram_data_a    (ram_data_a),
    .ram_data_b    (ram_data_b),
    .ram_data_aout (ram_data_aout),
    .ram_data_bout (ram_data_bout)
  );

  // Dual-bank synchronous RAM; cs picks the active bank, contents start at zero.
  logic [2:0] mem_a [8];
  logic [2:0] mem_b [8];
  initial begin
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    ram_data_aout = '0;
    ram_data_bout = '0;
  end
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem_a[ram_addr_a] <= ram_data_a;
      else        ram_data_aout <= mem_a[ram_addr_a];
    end else begin
      if (ram_we) mem_b[ram_addr_b] <= ram_data_b;
      else        ram_data_bout <= mem_b[ram_addr_b];
    end
  end

  // Reference: what each bank should hold, and which port was granted last (1 = B).
  int ref_a [8];
  int ref_b [8];
  bit last_b;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_a(input bit v, input bit we, input int addr, input int data);
    a_req_valid = v;
    a_req_we    = we;
    a_req_addr  = 3'(addr);
    a_req_wdata = 3'(data);
  endtask

  task automatic set_b(input bit v, input bit we, input int addr, input int data);
    b_req_valid = v;
    b_req_we    = we;
    b_req_addr  = 3'(addr);
    b_req_wdata = 3'(data);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n  = 1'b1;
    last_b = 1'b1;
  endtask

  // Serve one transaction from the current valids; called at a negedge. Ends at the RESP negedge.
  // hold_x keeps client x requesting (with a fresh random payload) after it is granted.
  task automatic serve_one(input bit hold_a, input bit hold_b, output bit got_a);
    int  n = 0;
    bit  exp_a, we;
    int  addr, wdata, exp_rd;
    got_a = 1'b0;
    while (!(a_req_ready || b_req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!(a_req_ready || b_req_ready)) begin
      check_eq("grant_timeout", 0, 1);
      return;
    end
    exp_a = a_req_valid && (!b_req_valid || !Rr || last_b);
    check_eq("one_ready", int'(a_req_ready && b_req_ready), 0);
    check_eq("grant_a", int'(a_req_ready), int'(exp_a));
    check_eq("idle_we", int'(ram_we), 0);
    got_a = a_req_ready;
    we    = got_a ? a_req_we : b_req_we;
    addr  = got_a ? int'(a_req_addr) : int'(b_req_addr);
    wdata = got_a ? int'(a_req_wdata) : int'(b_req_wdata);
    @(posedge clk);
    #1;
    last_b = !got_a;
    if (got_a) begin
      if (hold_a) set_a(1, 1'($urandom), $urandom_range(7), $urandom_range(7));
      else        a_req_valid = 1'b0;
    end else begin
      if (hold_b) set_b(1, 1'($urandom), $urandom_range(7), $urandom_range(7));
      else        b_req_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("issue_we", int'(ram_we), int'(we));
    check_eq("issue_cs", int'(ram_cs), int'(got_a));
    check_eq("issue_rsp", int'(a_rsp_valid || b_rsp_valid), 0);
    check_eq("issue_ready", int'(a_req_ready || b_req_ready), 0);
    @(negedge clk);
    exp_rd = we ? 0 : (got_a ? ref_a[addr] : ref_b[addr]);
    check_eq("resp_we", int'(ram_we), 0);
    check_eq("rsp_valid_a", int'(a_rsp_valid), int'(got_a));
    check_eq("rsp_valid_b", int'(b_rsp_valid), int'(!got_a));
    check_eq("rsp_rdata", got_a ? int'(a_rsp_rdata) : int'(b_rsp_rdata), exp_rd);
    if (we) begin
      if (got_a) ref_a[addr] = wdata;
      else       ref_b[addr] = wdata;
    end
  endtask

  initial begin
    bit g;
    int n;
    for (int i = 0; i < 8; i++) begin
      ref_a[i] = 0;
      ref_b[i] = 0;
    end
    last_b = 1'b1;
    rst_n  = 1'b0;
    set_a(1, 1, 5, 3);
    set_b(0, 0, 0, 0);

    // Reset held three cycles with A requesting.
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_ready", int'(a_req_ready), 0);
      check_eq("rst_we", int'(ram_we), 0);
      check_eq("rst_rsp", int'(a_rsp_valid || b_rsp_valid), 0);
      check_eq("rst_cs", int'(ram_cs), 1);
    end
    rst_n = 1'b1;
    #1;
    check_eq("first_grant_a", int'(a_req_ready), 1);

    // A write 5<-3, A read 5.
    serve_one(0, 0, g);
    set_a(1, 0, 5, 0);
    serve_one(0, 0, g);

    // B write 2<-6, A read 2 (bank A untouched), B read 2.
    set_b(1, 1, 2, 6);
    serve_one(0, 0, g);
    set_a(1, 0, 2, 0);
    serve_one(0, 0, g);
    set_b(1, 0, 2, 0);
    serve_one(0, 0, g);

    // Reset during ISSUE of an A write 1<-7 must drop it; prior value 4 survives.
    set_a(1, 1, 1, 4);
    serve_one(0, 0, g);
    set_a(1, 1, 1, 7);
    @(negedge clk);
    n = 0;
    while (!a_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst5_grant", int'(a_req_ready), 1);
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst5_we", int'(ram_we), 0);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst5_we_hold", int'(ram_we), 0);
      check_eq("rst5_rsp", int'(a_rsp_valid || b_rsp_valid), 0);
    end
    rst_n  = 1'b1;
    last_b = 1'b1;
    set_a(1, 0, 1, 0);
    serve_one(0, 0, g);

    // Both clients requesting continuously for six grants, from a fresh pointer.
    do_reset(2);
    set_a(1, 0, $urandom_range(7), 0);
    set_b(1, 0, $urandom_range(7), 0);
    for (int i = 0; i < 6; i++) begin
      serve_one(1, 1, g);
      check_eq("cont_grant_a", int'(g), Rr ? int'((i % 2) == 0) : 1);
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;

    // Random traffic, ties included; losers stay valid until served.
    for (int it = 0; it < 40; it++) begin
      int pick;
      pick = $urandom_range(1, 3);
      set_a(pick[0], 1'($urandom), $urandom_range(7), $urandom_range(7));
      set_b(pick[1], 1'($urandom), $urandom_range(7), $urandom_range(7));
      n = 0;
      while ((a_req_valid || b_req_valid) && n < 4) begin
        serve_one(0, 0, g);
        n++;
      end
      check_eq("rand_drained", int'(a_req_valid || b_req_valid), 0);
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
